// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MIPS MULT/MULTU/DIV/DIVU engine feeding the HiLo register.
// Computes one bit per clock: shift-add multiply or restoring divide on operand
// magnitudes, then applies sign correction and issues a one-cycle HiLo write.
//
// Ports:
//   Clk, Reset        clock and synchronous active-high reset
//   Start, Op, A, B   request (sampled only while idle); Op: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   Busy              high from the accepting edge until the Done cycle ends
//   Done              one-cycle result pulse
//   Hi/LoWriteEnable  HiLo write strobes, identical to Done
//   Hi/LoWriteData    MUL: product high/low half; DIV: remainder/quotient (held between ops)
module mult_div_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic [1:0]       Op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             Busy,
   output logic             Done,
   output logic             HiWriteEnable,
   output logic             LoWriteEnable,
   output logic [WIDTH-1:0] HiWriteData,
   output logic [WIDTH-1:0] LoWriteData
);

   localparam int unsigned CntW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} stateT;

   stateT            state;
   logic [CntW-1:0]  count;
   logic             isDiv;
   logic             negMain;   // negate product (MUL) or quotient (DIV)
   logic             negRem;    // remainder follows the dividend's sign
   logic             divZero;
   logic [WIDTH-1:0] opnd;      // multiplicand (MUL) or divisor (DIV) magnitude
   logic [WIDTH-1:0] hiAcc;     // product high half / partial remainder
   logic [WIDTH-1:0] loAcc;     // multiplier shifting out / dividend shifting into quotient

   logic             aNeg, bNeg;
   logic [WIDTH-1:0] aMag, bMag;
   logic [WIDTH:0]   mulSum;
   logic [WIDTH:0]   divShift, divTrial;
   logic [2*WIDTH-1:0] productNeg;
   logic [WIDTH-1:0] hiNeg, loNeg;

   // Operand magnitudes and per-iteration datapath values
   always_comb begin
      aNeg       = Op[0] & A[WIDTH-1];
      bNeg       = Op[0] & B[WIDTH-1];
      aMag       = aNeg ? (-A) : A;
      bMag       = bNeg ? (-B) : B;
      mulSum     = {1'b0, hiAcc} + (loAcc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
      divShift   = {hiAcc, loAcc[WIDTH-1]};
      // Bit WIDTH of the trial difference set means the divisor did not fit
      divTrial   = divShift - {1'b0, opnd};
      productNeg = -{hiAcc, loAcc};
      hiNeg      = -hiAcc;
      loNeg      = -loAcc;
   end

   assign HiWriteEnable = Done;
   assign LoWriteEnable = Done;

   // Control FSM and datapath registers
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state       <= IDLE;
         count       <= '0;
         isDiv       <= 1'b0;
         negMain     <= 1'b0;
         negRem      <= 1'b0;
         divZero     <= 1'b0;
         opnd        <= '0;
         hiAcc       <= '0;
         loAcc       <= '0;
         Busy        <= 1'b0;
         Done        <= 1'b0;
         HiWriteData <= '0;
         LoWriteData <= '0;
      end else begin
         Done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (Start) begin
                  isDiv   <= Op[1];
                  negMain <= aNeg ^ bNeg;
                  negRem  <= aNeg;
                  divZero <= Op[1] && (B == '0);
                  hiAcc   <= '0;
                  if (Op[1]) begin
                     opnd  <= bMag;
                     loAcc <= aMag;
                  end else begin
                     opnd  <= aMag;
                     loAcc <= bMag;
                  end
                  count <= CntW'(WIDTH);
                  Busy  <= 1'b1;
                  state <= RUN;
               end
            end
            RUN: begin
               if (isDiv) begin
                  if (divTrial[WIDTH]) begin
                     hiAcc <= divShift[WIDTH-1:0];
                     loAcc <= {loAcc[WIDTH-2:0], 1'b0};
                  end else begin
                     hiAcc <= divTrial[WIDTH-1:0];
                     loAcc <= {loAcc[WIDTH-2:0], 1'b1};
                  end
               end else begin
                  hiAcc <= mulSum[WIDTH:1];
                  loAcc <= {mulSum[0], loAcc[WIDTH-1:1]};
               end
               count <= count - CntW'(1);
               if (count == CntW'(1)) state <= FIX;
            end
            FIX: begin
               if (!isDiv) begin
                  {HiWriteData, LoWriteData} <= negMain ? productNeg : {hiAcc, loAcc};
               end else begin
                  HiWriteData <= negRem ? hiNeg : hiAcc;
                  // Divide by zero: quotient forced to all ones, remainder is A itself
                  if (divZero)      LoWriteData <= '1;
                  else if (negMain) LoWriteData <= loNeg;
                  else              LoWriteData <= loAcc;
               end
               Done  <= 1'b1;
               state <= DONE;
            end
            DONE: begin
               Busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: self-checking bench for mult_div_unit (directed table, reset abort, random vs reference model).
module tb_mult_div_unit;

   localparam int unsigned WIDTH = 32;
   localparam int          LAT   = WIDTH + 2;
   localparam int          WATCH = 40;

   logic             Clk = 1'b0;
   logic             Reset, Start;
   logic [1:0]       Op;
   logic [WIDTH-1:0] A, B;
   logic             Busy, Done, HiWriteEnable, LoWriteEnable;
   logic [WIDTH-1:0] HiWriteData, LoWriteData;

   int checks   = 0;
   int failures = 0;

   mult_div_unit #(.WIDTH(WIDTH)) dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
      .Busy(Busy), .Done(Done), .HiWriteEnable(HiWriteEnable), .LoWriteEnable(LoWriteEnable),
      .HiWriteData(HiWriteData), .LoWriteData(LoWriteData)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      int          ignoreAt;   // cycle in which a stray Start is raised (0 = none)
      logic [31:0] hi;
      logic [31:0] lo;
   } vecT;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: plain 64-bit arithmetic with MIPS divide-by-zero convention
   function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] hi, output logic [31:0] lo);
      longint sa, sb, p, q, r;
      if (op[0]) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
      end else begin
         sa = longint'({32'b0, a});
         sb = longint'({32'b0, b});
      end
      if (!op[1]) begin
         p  = sa * sb;
         hi = p[63:32];
         lo = p[31:0];
      end else if (b == 32'd0) begin
         hi = a;
         lo = 32'hFFFF_FFFF;
      end else begin
         q  = sa / sb;
         r  = sa % sb;
         hi = r[31:0];
         lo = q[31:0];
      end
   endfunction

   // Issue one op in cycle 0 and observe cycles 1..WATCH; inputs are scrambled while busy
   task automatic runOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int ignoreAt,
                        output logic [31:0] hi, output logic [31:0] lo,
                        output logic [31:0] holdHi, output logic [31:0] holdLo,
                        output int doneCycle, output int doneCount,
                        output bit busyOk, output bit enOk);
      Op = op; A = a; B = b; Start = 1'b1;
      hi = '0; lo = '0; doneCycle = -1; doneCount = 0; busyOk = 1'b1; enOk = 1'b1;
      for (int c = 1; c <= WATCH; c++) begin
         @(posedge Clk); #1;
         Start = (c == ignoreAt);
         Op    = 2'($urandom_range(0, 3));
         A     = $urandom;
         B     = $urandom;
         if (Done === 1'b1) begin
            doneCount++;
            if (doneCycle < 0) begin
               doneCycle = c;
               hi = HiWriteData;
               lo = LoWriteData;
            end
         end
         if (HiWriteEnable !== Done || LoWriteEnable !== Done) enOk = 1'b0;
         if (Busy !== (c <= LAT)) busyOk = 1'b0;
      end
      Start  = 1'b0;
      holdHi = HiWriteData;
      holdLo = LoWriteData;
   endtask

   task automatic runAndCheck(input string tag, input logic [1:0] op, input logic [31:0] a,
                              input logic [31:0] b, input int ignoreAt,
                              input logic [31:0] expHi, input logic [31:0] expLo);
      logic [31:0] hi, lo, holdHi, holdLo;
      int dc, dn;
      bit bOk, eOk;
      runOp(op, a, b, ignoreAt, hi, lo, holdHi, holdLo, dc, dn, bOk, eOk);
      check({tag, " latency"}, 64'(dc), 64'(LAT));
      check({tag, " done_pulses"}, 64'(dn), 64'd1);
      check({tag, " hi"}, 64'(hi), 64'(expHi));
      check({tag, " lo"}, 64'(lo), 64'(expLo));
      check({tag, " busy_window"}, 64'(bOk), 64'd1);
      check({tag, " enables"}, 64'(eOk), 64'd1);
      check({tag, " hold"}, {holdHi, holdLo}, {expHi, expLo});
   endtask

   initial begin
      vecT vecs[10];
      logic [31:0] mHi, mLo, ra, rb;
      logic [1:0]  rop;
      int seen;

      vecs[0] = '{2'b01, 32'hFFFF_FFFD, 32'd5,        0,  32'hFFFF_FFFF, 32'hFFFF_FFF1};
      vecs[1] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFE, 32'h0000_0001};
      vecs[2] = '{2'b11, 32'hFFFF_FFF9, 32'd2,        0,  32'hFFFF_FFFF, 32'hFFFF_FFFD};
      vecs[3] = '{2'b10, 32'd7,         32'd0,        0,  32'h0000_0007, 32'hFFFF_FFFF};
      vecs[4] = '{2'b10, 32'd100,       32'd7,        5,  32'h0000_0002, 32'h0000_000E};
      vecs[5] = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h0000_0000, 32'h8000_0000};
      vecs[6] = '{2'b11, 32'hFFFF_FFFB, 32'd0,        0,  32'hFFFF_FFFB, 32'hFFFF_FFFF};
      vecs[7] = '{2'b01, 32'h8000_0000, 32'h8000_0000, 0, 32'h4000_0000, 32'h0000_0000};
      vecs[8] = '{2'b11, 32'd7,         32'hFFFF_FFFE, LAT, 32'h0000_0001, 32'hFFFF_FFFD};
      vecs[9] = '{2'b00, 32'd0,         32'h1234_5678, 0, 32'h0000_0000, 32'h0000_0000};

      Reset = 1'b1; Start = 1'b0; Op = 2'b00; A = '0; B = '0;
      repeat (2) @(posedge Clk);
      #1;
      check("reset busy", 64'(Busy), 64'd0);
      check("reset done", 64'(Done), 64'd0);
      check("reset enables", 64'({HiWriteEnable, LoWriteEnable}), 64'd0);
      check("reset data", {HiWriteData, LoWriteData}, 64'd0);
      Reset = 1'b0;
      @(posedge Clk); #1;

      for (int i = 0; i < 10; i++)
         runAndCheck($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                     vecs[i].ignoreAt, vecs[i].hi, vecs[i].lo);

      // Reset in the middle of a MULTU aborts without a write
      Op = 2'b00; A = 32'h0001_2345; B = 32'h0000_0100; Start = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         @(posedge Clk); #1;
         Start = 1'b0;
         if (c == 10) Reset = 1'b1;
      end
      @(posedge Clk); #1;
      check("abort busy", 64'(Busy), 64'd0);
      check("abort done", 64'(Done), 64'd0);
      check("abort data", {HiWriteData, LoWriteData}, 64'd0);
      Reset = 1'b0;
      seen = 0;
      for (int c = 0; c < WATCH; c++) begin
         @(posedge Clk); #1;
         if (Done !== 1'b0 || HiWriteEnable !== 1'b0 || LoWriteEnable !== 1'b0 || Busy !== 1'b0)
            seen++;
      end
      check("abort no_write", 64'(seen), 64'd0);

      // Randomized operations against the reference model
      for (int n = 0; n < 120; n++) begin
         rop = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 7))
            0:       ra = 32'h8000_0000;
            1:       ra = 32'hFFFF_FFFF;
            2:       ra = 32'($urandom_range(0, 20));
            default: ra = $urandom;
         endcase
         case ($urandom_range(0, 7))
            0:       rb = 32'd0;
            1:       rb = 32'hFFFF_FFFF;
            2:       rb = 32'($urandom_range(1, 20));
            default: rb = $urandom;
         endcase
         model(rop, ra, rb, mHi, mLo);
         runAndCheck($sformatf("rnd%0d op%0d a=%h b=%h", n, rop, ra, rb), rop, ra, rb, 0, mHi, mLo);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
